// File: rtl/demux_pkg.sv
// Shared constants and slot-state encoding for the demux router.
package demux_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ERR_W  = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a single output channel (EMPTY/FULL FSM).
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next state: a load always wins (covers drain+load at full throughput);
  // drain only empties the slot when nothing new arrives, and is ignored while EMPTY.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = load_data;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          data_d = load_data;
        end else if (drain) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  // State and data registers; reset drops any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  // Data is gated so an empty channel always presents zeros.
  assign data  = valid ? data_q : '0;

endmodule

// File: rtl/demux_router.sv
// 1-to-NUM_CH valid/ready demultiplexer with a one-entry slot per channel
// and a saturating counter for words whose select names no channel.
module demux_router
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int ERR_W  = DEF_ERR_W,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     sel_err,
  output logic [ERR_W-1:0]         err_count
);

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] load;
  logic              sel_bad;
  logic              sel_blocked;
  logic              accept_bad;
  logic              sel_err_q, sel_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  assign sel_bad = ({1'b0, in_sel} >= NUM_CH_L);

  // Select decode: the addressed channel blocks only when it is full and
  // its consumer is not taking the word this cycle. A bad select matches
  // no channel, so it is never blocked and gets swallowed.
  always_comb begin
    sel_blocked = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_W'(k)) sel_blocked = out_valid[k] & ~out_ready[k];
    end
  end

  assign in_ready = enable & ~sel_blocked;

  // One-hot load strobe for the addressed slot.
  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = in_valid & in_ready & (in_sel == SEL_W'(k));
    end
  end

  assign accept_bad = in_valid & in_ready & sel_bad;

  // Error pulse follows the discarded word by one cycle; counter saturates.
  always_comb begin
    sel_err_d   = accept_bad;
    err_count_d = err_count_q;
    if (accept_bad && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
  end

  // Error pulse and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .load_data(in_data),
      .drain    (out_ready[g]),
      .valid    (out_valid[g]),
      .data     (out_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: per-channel expected-word queues fed by
// the driver, drained and compared by an independent negedge monitor.
module tb_demux_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic        sel_err;
  logic [7:0]  err_count;

  // shared stimulus for the two 3-channel instances
  logic        b_en = 1'b0, b_valid = 1'b0;
  logic [3:0]  b_data = '0;
  logic [1:0]  b_sel = '0;
  logic [2:0]  b_ordy = '0;
  logic        b3_ready, s_ready, b3_err, s_err;
  logic [11:0] b3_data, s_data;
  logic [2:0]  b3_valid, s_valid;
  logic [7:0]  b3_cnt;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  demux_router dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .err_count(err_count)
  );

  demux_router #(.DATA_W(4), .NUM_CH(3), .ERR_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .in_data(b_data), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(b3_ready), .out_data(b3_data), .out_valid(b3_valid),
    .out_ready(b_ordy), .sel_err(b3_err), .err_count(b3_cnt)
  );

  demux_router #(.DATA_W(4), .NUM_CH(3), .ERR_W(2)) dut3s (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .in_data(b_data), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(s_ready), .out_data(s_data), .out_valid(s_valid),
    .out_ready(b_ordy), .sel_err(s_err), .err_count(s_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [3:0] q [4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: slot occupancy/data against the model, pop on each drain.
  logic       ev;
  logic [3:0] ed;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        ev = (q[k].size() != 0);
        ed = ev ? q[k][0] : 4'h0;
        chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(ev));
        chk($sformatf("out_data[%0d]", k), 32'(out_data[k*4 +: 4]), 32'(ed));
        if (ev && out_ready[k]) void'(q[k].pop_front());
      end
      chk("sel_err_4ch", 32'(sel_err), 32'(0));
      chk("err_count_4ch", 32'(err_count), 32'(0));
    end
  end

  // Driver: apply one cycle of inputs, predict in_ready, record accepted words.
  task automatic step(input logic en, input logic v, input logic [1:0] s,
                      input logic [3:0] d, input logic [3:0] ordy);
    logic exp_rdy;
    enable = en; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    @(negedge clk); #1;
    exp_rdy = en & ((q[s].size() == 0) | ordy[s]);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (v && exp_rdy) q[s].push_back(d);
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_err_count", 32'(err_count), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset mid-traffic with slot 2 full
    step(1, 1, 2, 4'hE, 4'h0);
    chk("pre_rst_valid2", 32'(out_valid[2]), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'(0));
    chk("async_rst_data", 32'(out_data), 32'(0));
    chk("async_rst_cnt", 32'(err_count), 32'(0));
    for (int k = 0; k < 4; k++) q[k].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // routing to all four channels
    step(1, 1, 0, 4'hA, 4'h0);
    step(1, 1, 1, 4'h5, 4'h0);
    step(1, 1, 2, 4'hC, 4'h0);
    step(1, 1, 3, 4'h3, 4'h0);
    chk("route_valid", 32'(out_valid), 32'h0000_000F);
    chk("route_data", 32'(out_data), 32'h0000_3C5A);
    for (int s = 0; s < 4; s++) step(1, 1, 2'(s), 4'hF, 4'h0);

    // back-pressure on channel 1 only, then one word per cycle
    step(1, 1, 1, 4'h6, 4'b0000);
    step(1, 1, 0, 4'h8, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 4'h7, 4'b0010);
      chk("thru_valid1", 32'(out_valid[1]), 32'(1));
      chk("thru_data1", 32'(out_data[7:4]), 32'h7);
    end
    step(1, 0, 0, 4'h0, 4'hF);
    step(1, 0, 0, 4'h0, 4'hF);
    chk("drained", 32'(out_valid), 32'(0));

    // enable low stalls input but channel still drains
    step(1, 1, 0, 4'h9, 4'h0);
    step(0, 1, 0, 4'h1, 4'h0);
    chk("en_low_hold", 32'(out_data[3:0]), 32'h9);
    step(0, 1, 0, 4'h1, 4'b0001);
    step(0, 0, 0, 4'h0, 4'h0);
    chk("en_low_empty", 32'(out_valid[0]), 32'(0));

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'h0, 4'hF);

    // bad select on 3-channel instances (ERR_W=8 and ERR_W=2)
    b_en = 1'b1; b_valid = 1'b1; b_sel = 2'b11; b_data = 4'hF; b_ordy = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bad_in_ready", 32'(b3_ready), 32'(1));
      chk("bad_in_ready_s", 32'(s_ready), 32'(1));
      @(posedge clk); #1;
      chk("bad_sel_err", 32'(b3_err), 32'(1));
      chk("bad_sel_err_s", 32'(s_err), 32'(1));
      chk("bad_cnt", 32'(b3_cnt), 32'(i + 1));
      chk("bad_cnt_sat", 32'(s_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    chk("bad_pulse_end", 32'(b3_err), 32'(0));
    chk("bad_cnt_final", 32'(b3_cnt), 32'(5));
    chk("bad_cnt_sat_final", 32'(s_cnt), 32'(3));
    chk("bad_no_valid", 32'(b3_valid), 32'(0));
    chk("bad_no_valid_s", 32'(s_valid), 32'(0));
    b_en = 1'b0; b_valid = 1'b1;
    @(negedge clk);
    chk("bad_en_low_ready", 32'(b3_ready), 32'(0));
    @(posedge clk); #1;
    chk("bad_en_low_err", 32'(b3_err), 32'(0));
    chk("bad_en_low_cnt", 32'(b3_cnt), 32'(5));
    b_en = 1'b1; b_sel = 2'd2; b_data = 4'h6;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("ch3_valid", 32'(b3_valid), 32'b100);
    chk("ch3_data", 32'(b3_data), 32'h600);
    chk("ch3_no_err", 32'(b3_err), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
